// File: rtl/fp16_div.sv
// ============================================================================
// Module   : fp16_div
// Purpose  : Sequential FP16 divider, one quotient bit per cycle, truncating.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp16_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        overflow,
    output logic        div_by_zero
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_NORM   = 2'd2;

    localparam logic [3:0]  c_LAST_ITER = 4'd11;
    localparam logic [15:0] c_QNAN      = 16'h7E00;
    localparam logic [14:0] c_INF_MAG   = 15'h7C00;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic              r_special;
    logic [15:0]       r_spec_res;
    logic              r_spec_ovf;
    logic              r_spec_dbz;
    logic              r_sign;
    logic signed [6:0] r_exp;
    logic [11:0]       r_rem;
    logic [10:0]       r_div;
    logic [11:0]       r_q;
    logic [3:0]        r_cnt;
    logic [15:0]       r_result;
    logic              r_ovf;
    logic              r_dbz;
    logic              r_done;

    // Operand classification on the live inputs; only used on the start edge.
    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_in_sign;
    logic        w_special;
    logic [15:0] w_spec_res;
    logic        w_spec_ovf;
    logic        w_spec_dbz;

    assign w_a_zero  = (a[14:10] == 5'd0);
    assign w_b_zero  = (b[14:10] == 5'd0);
    assign w_a_inf   = (a[14:10] == 5'h1F);
    assign w_b_inf   = (b[14:10] == 5'h1F);
    assign w_in_sign = a[15] ^ b[15];

    always_comb begin
        w_special  = 1'b1;
        w_spec_res = 16'h0000;
        w_spec_ovf = 1'b0;
        w_spec_dbz = 1'b0;
        if (w_a_zero && w_b_zero) begin
            w_spec_res = c_QNAN;
            w_spec_dbz = 1'b1;
        end else if (w_b_zero) begin
            w_spec_res = {w_in_sign, c_INF_MAG};
            w_spec_dbz = 1'b1;
        end else if (w_a_inf && w_b_inf) begin
            w_spec_res = c_QNAN;
        end else if (w_a_inf) begin
            w_spec_res = {w_in_sign, c_INF_MAG};
            w_spec_ovf = 1'b1;
        end else if (w_a_zero || w_b_inf) begin
            w_spec_res = {w_in_sign, 15'h0000};
        end else begin
            w_special = 1'b0;
        end
    end

    // Restoring step: remainder stays below 2*divisor, so 12 bits suffice.
    logic        w_ge;
    logic [11:0] w_rem_next;

    assign w_ge       = (r_rem >= {1'b0, r_div});
    assign w_rem_next = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_special ? S_NORM : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (r_cnt == c_LAST_ITER) begin
                    w_next_state = S_NORM;
                end
            end
            S_NORM:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    logic signed [6:0] w_norm_exp;
    logic [9:0]        w_mant;
    logic [15:0]       w_res;
    logic              w_ovf;
    logic              w_dbz;

    always_comb begin
        w_norm_exp = r_q[11] ? r_exp : (r_exp - 7'sd1);
        w_mant     = r_q[11] ? r_q[10:1] : r_q[9:0];
        w_res      = {r_sign, w_norm_exp[4:0], w_mant};
        w_ovf      = 1'b0;
        w_dbz      = 1'b0;
        if (r_special) begin
            w_res = r_spec_res;
            w_ovf = r_spec_ovf;
            w_dbz = r_spec_dbz;
        end else if (w_norm_exp >= 7'sd31) begin
            w_res = {r_sign, c_INF_MAG};
            w_ovf = 1'b1;
        end else if (w_norm_exp <= 7'sd0) begin
            w_res = {r_sign, 15'h0000};
        end
    end

    // ------------------------------------------------------------- Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_special  <= 1'b0;
            r_spec_res <= 16'h0000;
            r_spec_ovf <= 1'b0;
            r_spec_dbz <= 1'b0;
            r_sign     <= 1'b0;
            r_exp      <= 7'sd0;
            r_rem      <= 12'd0;
            r_div      <= 11'd0;
            r_q        <= 12'd0;
            r_cnt      <= 4'd0;
            r_result   <= 16'h0000;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_special  <= w_special;
                        r_spec_res <= w_spec_res;
                        r_spec_ovf <= w_spec_ovf;
                        r_spec_dbz <= w_spec_dbz;
                        r_sign     <= w_in_sign;
                        r_exp      <= $signed({2'b00, a[14:10]}) - $signed({2'b00, b[14:10]}) + 7'sd15;
                        r_rem      <= {2'b01, a[9:0]};
                        r_div      <= {1'b1, b[9:0]};
                        r_q        <= 12'd0;
                        r_cnt      <= 4'd0;
                    end
                end
                S_DIVIDE: begin
                    r_q   <= {r_q[10:0], w_ge};
                    r_rem <= {w_rem_next[10:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                end
                S_NORM: begin
                    r_result <= w_res;
                    r_ovf    <= w_ovf;
                    r_dbz    <= w_dbz;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign result      = r_result;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_fp16_div.sv
// ============================================================================
// Module   : tb_fp16_div
// Purpose  : Directed, table-driven check of fp16_div plus handshake corners.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fp16_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        overflow;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    fp16_div dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ovf;
        logic        dbz;
        int          lat;
    } vec_t;

    localparam int c_NVEC    = 15;
    localparam int c_TIMEOUT = 40;

    vec_t vecs[c_NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts edges after the start edge until done is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < c_TIMEOUT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Drives start for exactly the next edge (edge 0), returns #1 after it.
    task automatic issue(input logic [15:0] va, input logic [15:0] vb);
        start = 1'b1;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'hxxxx;
        b     = 16'hxxxx;
    endtask

    int  cyc;
    bit  seen_done;

    initial begin
        vecs[0]  = '{16'h4600, 16'h4000, 16'h4200, 1'b0, 1'b0, 13};
        vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0, 13};
        vecs[2]  = '{16'hBE00, 16'h3800, 16'hC200, 1'b0, 1'b0, 13};
        vecs[3]  = '{16'h3C00, 16'h0000, 16'h7C00, 1'b0, 1'b1, 1};
        vecs[4]  = '{16'h0000, 16'h0000, 16'h7E00, 1'b0, 1'b1, 1};
        vecs[5]  = '{16'h7800, 16'h2000, 16'h7C00, 1'b1, 1'b0, 13};
        vecs[6]  = '{16'h0400, 16'h7800, 16'h0000, 1'b0, 1'b0, 13};
        vecs[7]  = '{16'h7C00, 16'h7C00, 16'h7E00, 1'b0, 1'b0, 1};
        vecs[8]  = '{16'hFC00, 16'h4000, 16'hFC00, 1'b1, 1'b0, 1};
        vecs[9]  = '{16'h0000, 16'hC000, 16'h8000, 1'b0, 1'b0, 1};
        vecs[10] = '{16'h3C00, 16'hFC00, 16'h8000, 1'b0, 1'b0, 1};
        vecs[11] = '{16'h0001, 16'h3C00, 16'h0000, 1'b0, 1'b0, 1};
        vecs[12] = '{16'hBC00, 16'h0000, 16'hFC00, 1'b0, 1'b1, 1};
        vecs[13] = '{16'h3E00, 16'h3C00, 16'h3E00, 1'b0, 1'b0, 13};
        vecs[14] = '{16'h7C01, 16'h4000, 16'h7C00, 1'b1, 1'b0, 1};

        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {16'd0, result}, 32'h0000);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < c_NVEC; i++) begin
            issue(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            wait_done(cyc);
            check($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
            check($sformatf("v%0d_result", i), {16'd0, result}, {16'd0, vecs[i].res});
            check($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
            check($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
            check($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_result_held", i), {16'd0, result}, {16'd0, vecs[i].res});
        end

        // Start during an operation is ignored; start in the done cycle is taken.
        issue(16'h4600, 16'h4000);
        repeat (2) @(posedge clk);
        #1;
        issue(16'h3C00, 16'h4200);
        wait_done(cyc);
        check("ignore_latency", cyc + 3, 13);
        check("ignore_result", {16'd0, result}, 32'h4200);
        issue(16'h3C00, 16'h4200);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        check("b2b_latency", cyc, 13);
        check("b2b_result", {16'd0, result}, 32'h3555);

        // Reset mid-operation aborts without a done pulse.
        @(posedge clk);
        #1;
        issue(16'h4600, 16'h4000);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", {16'd0, result}, 32'h0000);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        issue(16'h4600, 16'h4000);
        wait_done(cyc);
        check("after_abort_latency", cyc, 13);
        check("after_abort_result", {16'd0, result}, 32'h4200);
        check("after_abort_ovf", {31'd0, overflow}, 32'd0);
        check("after_abort_dbz", {31'd0, div_by_zero}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
